// File: rtl/truth_table_sweeper_if.sv
// Stimulus/result bundle between the truth-table sweeper (master) and its harness (slave).
// N_IN must match the sweeper instance it is connected to.
interface truth_table_sweeper_if #(
  parameter int N_IN = 2
);
  localparam int DEPTH = 1 << N_IN;

  logic              start;
  logic [N_IN-1:0]   stim;
  logic              dut_out;
  logic [DEPTH-1:0]  expected;
  logic              busy;
  logic              done;
  logic              pass;
  logic [DEPTH-1:0]  result;
  logic [N_IN:0]     mismatch_cnt;
  logic [N_IN-1:0]   first_fail_idx;
  logic              fail_valid;

  modport master (
    input  start, dut_out, expected,
    output stim, busy, done, pass, result, mismatch_cnt, first_fail_idx, fail_valid
  );

  modport slave (
    output start, dut_out, expected,
    input  stim, busy, done, pass, result, mismatch_cnt, first_fail_idx, fail_valid
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks all 2^N_IN codes, holds each SETTLE_CYC cycles, samples and scores.
// Define SWEEP_GRAY_EN for a Gray-coded stim order (result/expected stay indexed by stim value).
module truth_table_sweeper #(
  parameter int N_IN         = 2,
  parameter int SETTLE_CYC   = 1,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.master bus
);
  localparam int DEPTH = 1 << N_IN;
  localparam int CW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int MW    = N_IN + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] result_q, result_d;
  logic [MW-1:0]    mcnt_q, mcnt_d;
  logic [N_IN-1:0]  ffi_q, ffi_d;
  logic             fv_q, fv_d;
  logic             mis;

  function automatic logic [N_IN-1:0] code_of(input logic [N_IN-1:0] i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      stim_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      mcnt_q   <= '0;
      ffi_q    <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      stim_q   <= stim_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      mcnt_q   <= mcnt_d;
      ffi_q    <= ffi_d;
      fv_q     <= fv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stim_d   = stim_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    mcnt_d   = mcnt_q;
    ffi_d    = ffi_q;
    fv_d     = fv_q;
    mis      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = SETTLE;
          idx_d    = '0;
          stim_d   = '0;
          cnt_d    = '0;
          result_d = '0;
          mcnt_d   = '0;
          ffi_d    = '0;
          fv_d     = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYC - 1)) state_d = SAMPLE;
        else                              cnt_d   = cnt_q + CW'(1);
      end
      SAMPLE: begin
        result_d[stim_q] = bus.dut_out;
        mis = (bus.dut_out != bus.expected[stim_q]);
        if (mis) begin
          if (mcnt_q != MW'(DEPTH)) mcnt_d = mcnt_q + MW'(1);
          if (!fv_q) begin
            ffi_d = stim_q;
            fv_d  = 1'b1;
          end
        end
        if ((idx_q == {N_IN{1'b1}}) || ((STOP_ON_FAIL != 0) && mis)) begin
          state_d = DONE;
        end else begin
          // stim only moves here, so the DUT input is stable for a whole vector period
          idx_d   = idx_q + N_IN'(1);
          stim_d  = code_of(idx_q + N_IN'(1));
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stim           = stim_q;
  assign bus.busy           = (state_q == SETTLE) || (state_q == SAMPLE);
  assign bus.done           = (state_q == DONE);
  assign bus.pass           = (state_q == DONE) && (mcnt_q == '0);
  assign bus.result         = result_q;
  assign bus.mismatch_cnt   = mcnt_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.fail_valid     = fv_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: NOR DUT on two sweepers (full sweep / stop-on-fail), XOR3 DUT on an N_IN=3 sweeper.
module tb_truth_table_sweeper;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(2)) ifa ();
  truth_table_sweeper_if #(.N_IN(2)) ifb ();
  truth_table_sweeper_if #(.N_IN(3)) ifc ();

  truth_table_sweeper #(.N_IN(2), .SETTLE_CYC(1), .STOP_ON_FAIL(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  truth_table_sweeper #(.N_IN(2), .SETTLE_CYC(1), .STOP_ON_FAIL(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  truth_table_sweeper #(.N_IN(3), .SETTLE_CYC(1), .STOP_ON_FAIL(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  // Blocks under test: z = ~x & ~y with stim = {x,y}; and 3-input XOR
  assign ifa.dut_out = ~ifa.stim[1] & ~ifa.stim[0];
  assign ifb.dut_out = ~ifb.stim[1] & ~ifb.stim[0];
  assign ifc.dut_out = ^ifc.stim;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] exp_mask;
    logic [3:0] res;
    logic       pass;
    logic [2:0] mcnt;
    logic [1:0] ffi;
    logic       fv;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_a(input bit pulse_mid, output int cyc);
    cyc = 0;
    while (cyc < 100 && !ifa.done) begin
      ifa.start = pulse_mid && (cyc == 2);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    ifa.start = 1'b0;
  endtask

  task automatic run_a(input logic [3:0] mask, input bit pulse_mid, output int cyc);
    ifa.expected = mask;
    ifa.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    wait_a(pulse_mid, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [2:0] seq[8];
    logic [2:0] exp_seq[8];

    ifa.start = 1'b0; ifa.expected = '0;
    ifb.start = 1'b0; ifb.expected = '0;
    ifc.start = 1'b0; ifc.expected = '0;

`ifdef SWEEP_GRAY_EN
    exp_seq = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`else
    exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif

    vecs[0] = '{4'b0001, 4'b0001, 1'b1, 3'd0, 2'd0, 1'b0};
    vecs[1] = '{4'b0011, 4'b0001, 1'b0, 3'd1, 2'd1, 1'b1};
    vecs[2] = '{4'b1110, 4'b0001, 1'b0, 3'd4, 2'd0, 1'b1};
    vecs[3] = '{4'b0000, 4'b0001, 1'b0, 3'd1, 2'd0, 1'b1};
    vecs[4] = '{4'b1001, 4'b0001, 1'b0, 3'd1, 2'd3, 1'b1};

    #12;
    check("rst_stim",   32'(ifa.stim), 32'd0);
    check("rst_result", 32'(ifa.result), 32'd0);
    check("rst_mcnt",   32'(ifa.mismatch_cnt), 32'd0);
    check("rst_flags",  32'({ifa.busy, ifa.done, ifa.pass, ifa.fail_valid}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_a(vecs[i].exp_mask, 1'b0, cyc);
      check("tbl_cycles", 32'(cyc), 32'd8);
      check("tbl_result", 32'(ifa.result), 32'(vecs[i].res));
      check("tbl_pass",   32'(ifa.pass), 32'(vecs[i].pass));
      check("tbl_mcnt",   32'(ifa.mismatch_cnt), 32'(vecs[i].mcnt));
      check("tbl_ffi",    32'(ifa.first_fail_idx), 32'(vecs[i].ffi));
      check("tbl_fv",     32'(ifa.fail_valid), 32'(vecs[i].fv));
    end

    // Holding start in DONE restarts with a cleared scoreboard
    run_a(4'b0011, 1'b0, cyc);
    ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    check("restart_done_busy", 32'({ifa.done, ifa.busy}), 32'b01);
    check("restart_result",    32'(ifa.result), 32'd0);
    check("restart_mcnt_fv",   32'({ifa.mismatch_cnt, ifa.fail_valid}), 32'd0);
    wait_a(1'b0, cyc);
    check("restart_cycles", 32'(cyc), 32'd8);
    check("restart_final",  32'({ifa.result, ifa.mismatch_cnt}), 32'({4'b0001, 3'd1}));

    // start while busy must not lengthen the sweep
    run_a(4'b0001, 1'b1, cyc);
    check("ignore_cycles", 32'(cyc), 32'd8);
    check("ignore_result", 32'({ifa.result, ifa.pass}), 32'({4'b0001, 1'b1}));

    // Asynchronous reset mid-sweep
    ifa.expected = 4'b0001;
    ifa.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_stim",   32'(ifa.stim), 32'd0);
    check("midrst_result", 32'(ifa.result), 32'd0);
    check("midrst_flags",  32'({ifa.busy, ifa.done, ifa.pass, ifa.fail_valid}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_a(4'b0001, 1'b0, cyc);
    check("postrst_cycles", 32'(cyc), 32'd8);
    check("postrst_result", 32'({ifa.result, ifa.pass}), 32'({4'b0001, 1'b1}));

    // Stop-on-fail ends at the first mismatching vector
    ifb.expected = 4'b1111;
    ifb.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifb.start = 1'b0;
    cyc = 0;
    while (cyc < 100 && !ifb.done) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("sof_cycles", 32'(cyc), 32'd4);
    check("sof_result", 32'(ifb.result), 32'b0001);
    check("sof_mcnt",   32'(ifb.mismatch_cnt), 32'd1);
    check("sof_ffi",    32'({ifb.first_fail_idx, ifb.fail_valid, ifb.pass}), 32'({2'd1, 1'b1, 1'b0}));

    // N_IN=3 XOR sweep; stim order depends on the Gray option
    ifc.expected = 8'b10010110;
    ifc.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
    seq[0] = ifc.stim;
    cyc = 0;
    while (cyc < 100 && !ifc.done) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc < 16 && (cyc % 2) == 0) seq[cyc/2] = ifc.stim;
    end
    check("xor_cycles", 32'(cyc), 32'd16);
    for (int k = 0; k < 8; k++) check("xor_stim_seq", 32'(seq[k]), 32'(exp_seq[k]));
    check("xor_result", 32'(ifc.result), 32'b10010110);
    check("xor_pass",   32'({ifc.pass, ifc.mismatch_cnt}), 32'({1'b1, 4'd0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
